// File: rtl/axi_xbar_pkg.sv
// Shared crossbar definitions: payload widths, AW/W field offsets and the
// write-arbiter state encoding.
package axi_xbar_pkg;

    localparam int unsigned AW_W        = 49;
    localparam int unsigned W_W         = 37;
    localparam int unsigned AW_LEN_LSB  = 5;
    localparam int unsigned AW_ADDR_LSB = 9;
    localparam int unsigned AW_ID_LSB   = 41;
    localparam int unsigned W_LAST_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE,
        AW_SEND,
        W_BURST
    } wr_state_e;

    // AXI len encodes beats-1; widened so len=15 yields 16 without wrapping.
    function automatic logic [4:0] burst_beats(input logic [3:0] len);
        return {1'b0, len} + 5'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner when the grant is consumed.
module rr_arbiter #(
    parameter  int unsigned N     = 3,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_found;
    int unsigned      w_idx;

    always_comb begin
        o_gnt     = '0;
        w_found   = 1'b0;
        w_ptr_nxt = r_ptr;
        w_idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = (32'(r_ptr) + i) % N;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_ptr_nxt    = PTR_W'((w_idx + 1) % N);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/slave_wr_arbiter.sv
// Per-slave write arbiter: round-robin AW grant, then W channel locked to the
// granted master until its beat count is exhausted.
module slave_wr_arbiter #(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned AW_W      = 49,
    parameter int unsigned W_W       = 37
) (
    input  logic                      AXI_CLK_i,
    input  logic                      AXI_RST_i,
    input  logic [N_MASTERS-1:0]      m_aw_valid_i,
    input  logic [N_MASTERS*AW_W-1:0] m_aw_data_i,
    input  logic [N_MASTERS-1:0]      m_w_valid_i,
    input  logic [N_MASTERS*W_W-1:0]  m_w_data_i,
    input  logic                      s_awready_i,
    input  logic                      s_wready_i,
    output logic [N_MASTERS-1:0]      aw_grant_o,
    output logic [N_MASTERS-1:0]      w_grant_o,
    output logic                      s_awvalid_o,
    output logic [AW_W-1:0]           s_aw_data_o,
    output logic                      s_wvalid_o,
    output logic [W_W-1:0]            s_w_data_o,
    output logic                      len_err_o,
    output logic                      busy_o
);
    import axi_xbar_pkg::*;

    localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    wr_state_e            r_state;
    wr_state_e            w_state_nxt;
    logic [4:0]           r_beats_left;
    logic [AW_W-1:0]      r_aw_data;
    logic [N_MASTERS-1:0] w_rr_gnt;
    logic [IDX_W-1:0]     w_rr_ptr;
    logic [IDX_W-1:0]     w_owner;
    logic [AW_W-1:0]      w_aw_sel;
    logic [W_W-1:0]       w_w_cur;
    logic                 w_aw_req;
    logic                 w_rr_advance;
    logic                 w_w_hs;

    rr_arbiter #(.N(N_MASTERS)) u_rr (
        .i_clk     (AXI_CLK_i),
        .i_rst     (AXI_RST_i),
        .i_req     (m_aw_valid_i),
        .i_advance (w_rr_advance),
        .o_gnt     (w_rr_gnt),
        .o_ptr     (w_rr_ptr)
    );

    // The pointer only moves on a grant, to winner+1, so while busy the owner
    // is always the master just behind it.
    assign w_owner  = (w_rr_ptr == '0) ? IDX_W'(N_MASTERS - 1) : w_rr_ptr - 1'b1;
    assign w_aw_req = !AXI_RST_i && (|m_aw_valid_i);
    assign w_w_cur  = m_w_data_i[32'(w_owner) * W_W +: W_W];

    always_comb begin
        w_aw_sel = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (w_rr_gnt[k]) begin
                w_aw_sel = w_aw_sel | m_aw_data_i[k*AW_W +: AW_W];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        aw_grant_o   = '0;
        w_grant_o    = '0;
        s_awvalid_o  = 1'b0;
        s_wvalid_o   = 1'b0;
        s_w_data_o   = '0;
        len_err_o    = 1'b0;
        w_rr_advance = 1'b0;
        w_w_hs       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_aw_req) begin
                    aw_grant_o   = w_rr_gnt;
                    w_rr_advance = 1'b1;
                    w_state_nxt  = AW_SEND;
                end
            end
            AW_SEND: begin
                s_awvalid_o = 1'b1;
                if (s_awready_i) begin
                    w_state_nxt = W_BURST;
                end
            end
            W_BURST: begin
                s_wvalid_o = m_w_valid_i[w_owner];
                s_w_data_o = w_w_cur;
                w_w_hs     = s_wvalid_o && s_wready_i;
                if (w_w_hs) begin
                    w_grant_o[w_owner] = 1'b1;
                    len_err_o = w_w_cur[W_LAST_BIT] ^ (r_beats_left == 5'd1);
                    if (r_beats_left == 5'd1) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
        if (AXI_RST_i) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_aw_data    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_aw_req) begin
                r_aw_data    <= w_aw_sel;
                r_beats_left <= burst_beats(w_aw_sel[AW_LEN_LSB +: 4]);
            end else if (w_w_hs) begin
                r_beats_left <= r_beats_left - 5'd1;
            end
        end
    end

    assign s_aw_data_o = r_aw_data;
    assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_slave_wr_arbiter.sv
// Transaction-level bench: each write is walked through grant, AW handshake
// and W beats with expectations derived from round-robin and beat-count rules.
module tb_slave_wr_arbiter;
    import axi_xbar_pkg::*;

    localparam int unsigned N = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       m_aw_valid;
    logic [N*AW_W-1:0]  m_aw_data;
    logic [N-1:0]       m_w_valid;
    logic [N*W_W-1:0]   m_w_data;
    logic               s_awready;
    logic               s_wready;
    logic [N-1:0]       aw_grant;
    logic [N-1:0]       w_grant;
    logic               s_awvalid;
    logic [AW_W-1:0]    s_aw_data;
    logic               s_wvalid;
    logic [W_W-1:0]     s_w_data;
    logic               len_err;
    logic               busy;

    logic [AW_W-1:0]    awd [N];
    logic [W_W-1:0]     wd  [N];
    int                 checks = 0;
    int                 errors = 0;
    int                 ptr_m  = 0;

    always #5 clk = ~clk;

    slave_wr_arbiter #(.N_MASTERS(N), .AW_W(AW_W), .W_W(W_W)) dut (
        .AXI_CLK_i    (clk),
        .AXI_RST_i    (rst),
        .m_aw_valid_i (m_aw_valid),
        .m_aw_data_i  (m_aw_data),
        .m_w_valid_i  (m_w_valid),
        .m_w_data_i   (m_w_data),
        .s_awready_i  (s_awready),
        .s_wready_i   (s_wready),
        .aw_grant_o   (aw_grant),
        .w_grant_o    (w_grant),
        .s_awvalid_o  (s_awvalid),
        .s_aw_data_o  (s_aw_data),
        .s_wvalid_o   (s_wvalid),
        .s_w_data_o   (s_w_data),
        .len_err_o    (len_err),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            m_aw_data[k*AW_W +: AW_W] = awd[k];
            m_w_data[k*W_W +: W_W]    = wd[k];
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int p);
        for (int i = 0; i < N; i++) begin
            if (req[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [AW_W-1:0] mk_aw(input logic [3:0] len, input logic [31:0] addr);
        logic [AW_W-1:0] r;
        r = '0;
        r[AW_ID_LSB +: 8]    = 8'($urandom);
        r[AW_ADDR_LSB +: 32] = addr;
        r[AW_LEN_LSB +: 4]   = len;
        r[4:0]               = 5'($urandom);
        return r;
    endfunction

    task automatic rand_aw();
        for (int k = 0; k < N; k++) awd[k] = mk_aw(4'($urandom_range(0, 5)), $urandom);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_aw_grant"}, aw_grant, 0);
        chk({tag, "_w_grant"}, w_grant, 0);
        chk({tag, "_s_awvalid"}, s_awvalid, 0);
        chk({tag, "_s_wvalid"}, s_wvalid, 0);
        chk({tag, "_len_err"}, len_err, 0);
    endtask

    // wr_mode: 0 random ready, 1 ready toggling from 1, 2 always ready.
    // bad_beat: beat index (0-based) whose last flag is wrong, -1 for none.
    // abort_after: leave the burst after that many beats, -1 to complete.
    task automatic txn(input logic [N-1:0] req, input int aw_wait, input int wr_mode,
                       input int bad_beat, input int abort_after, output int winner);
        logic [AW_W-1:0] exp_aw;
        int beats, left, done, cyc;
        logic rdy, hs;
        m_aw_valid = req;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        m_w_valid  = '0;
        pack();
        #1;
        winner = pick(req, ptr_m);
        chk("idle_busy", busy, 0);
        chk("aw_grant", aw_grant, 64'd1 << winner);
        chk("idle_awvalid", s_awvalid, 0);
        chk("idle_w_grant", w_grant, 0);
        exp_aw = awd[winner];
        beats  = int'(exp_aw[AW_LEN_LSB +: 4]) + 1;
        ptr_m  = (winner + 1) % N;
        step();
        m_aw_valid = N'($urandom);
        for (int d = 0; d <= aw_wait; d++) begin
            s_awready = (d == aw_wait);
            #1;
            chk("aw_valid", s_awvalid, 1);
            chk("aw_data", s_aw_data, exp_aw);
            chk("aw_regrant", aw_grant, 0);
            chk("aw_w_grant", w_grant, 0);
            chk("aw_busy", busy, 1);
            step();
        end
        s_awready  = 1'b0;
        m_aw_valid = '0;
        left = beats;
        done = 0;
        cyc  = 0;
        while (left > 0 && cyc < 200 && !(abort_after >= 0 && done == abort_after)) begin
            for (int k = 0; k < N; k++) wd[k] = {$urandom, 5'($urandom)};
            m_w_valid = N'($urandom);
            m_w_valid[winner] = (wr_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdy = (wr_mode == 1) ? (cyc % 2 == 0) : (wr_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_wready = rdy;
            wd[winner][W_LAST_BIT] = (done == bad_beat) ? (left != 1) : (left == 1);
            pack();
            #1;
            hs = m_w_valid[winner] && rdy;
            chk("w_valid", s_wvalid, m_w_valid[winner]);
            chk("w_data", s_w_data, wd[winner]);
            chk("w_grant", w_grant, hs ? (64'd1 << winner) : 64'd0);
            chk("len_err", len_err, hs && (done == bad_beat));
            chk("w_aw_grant", aw_grant, 0);
            chk("w_busy", busy, 1);
            step();
            if (hs) begin
                done++;
                left--;
            end
            cyc++;
        end
        if (abort_after < 0) begin
            chk("burst_beats", done, beats);
            m_w_valid = '0;
            s_wready  = 1'b0;
            #1;
            check_quiet("post");
        end
    endtask

    initial begin
        int w;
        logic [N-1:0] req;
        int len, bb;
        rst = 1'b1;
        m_aw_valid = '0;
        m_w_valid  = '0;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        for (int k = 0; k < N; k++) begin
            awd[k] = '0;
            wd[k]  = '0;
        end
        pack();
        step();
        check_quiet("reset");
        chk("reset_aw_data", s_aw_data, 0);
        chk("reset_w_data", s_w_data, 0);
        step();
        rst = 1'b0;
        step();

        #1;
        check_quiet("idle_noreq");
        step();
        chk("idle_stays", busy, 0);

        // single write, master 1, len 0
        rand_aw();
        awd[1] = mk_aw(4'd0, 32'h0001_0000);
        txn(3'b010, 0, 2, -1, -1, w);

        // contention, all len 0
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N; k++) awd[k] = mk_aw(4'd0, $urandom);
            txn(3'b111, 0, 2, -1, -1, w);
        end

        // AW backpressure for 3 cycles
        rand_aw();
        txn(3'b001, 3, 0, -1, -1, w);

        // len 3 with toggling ready
        rand_aw();
        awd[2] = mk_aw(4'd3, $urandom);
        txn(3'b100, 0, 1, -1, -1, w);

        // early last on beat 2 of len 3
        rand_aw();
        awd[1] = mk_aw(4'd3, $urandom);
        txn(3'b010, 1, 2, 1, -1, w);

        // longest burst
        rand_aw();
        awd[0] = mk_aw(4'd15, $urandom);
        txn(3'b001, 0, 0, -1, -1, w);

        // randomized traffic
        for (int i = 0; i < 25; i++) begin
            rand_aw();
            req = N'($urandom_range(1, (1 << N) - 1));
            len = int'(awd[pick(req, ptr_m)][AW_LEN_LSB +: 4]);
            bb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
            txn(req, int'($urandom_range(0, 3)), 0, bb, -1, w);
        end

        // reset in the middle of a 4-beat burst
        rand_aw();
        awd[0] = mk_aw(4'd3, $urandom);
        txn(3'b001, 0, 2, -1, 2, w);
        m_aw_valid = '1;
        m_w_valid  = '1;
        s_wready   = 1'b1;
        s_awready  = 1'b1;
        rst = 1'b1;
        #1;
        check_quiet("midrst");
        chk("midrst_aw_data", s_aw_data, 0);
        chk("midrst_w_data", s_w_data, 0);
        step();
        rst = 1'b0;
        ptr_m = 0;
        m_w_valid = '0;
        rand_aw();
        txn(3'b101, 0, 2, -1, -1, w);
        rand_aw();
        txn(3'b100, 0, 2, -1, -1, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/slave_wr_arbiter.md
Name: slave_wr_arbiter

Overview:
- Per-slave write-path arbiter on the AXI-clock side of the crossbar; one instance per slave port.
- Consumes the per-slave AW/W valid bits and FIFO head data that every master interface presents after its async FIFOs and address decoder.
- Grants one master round-robin and pops that master's AW FIFO via the grant bit. Locks the W channel to that master until the burst completes, and drives the slave-side AW/W signals.

Parameters:
- N_MASTERS, 3, number of master interfaces competing for this slave
- AW_W, 49, AW payload width: {id[7:0], addr[31:0], len[3:0], size[2:0], burst[1:0]}
- W_W, 37, W payload width: {data[31:0], strb[3:0], last}

Ports:
- AXI_CLK_i  in  1  AXI-domain clock
- AXI_RST_i  in  1  reset, asynchronous, active-high
- m_aw_valid_i  in  N_MASTERS  per-master AW valid for this slave (decoder output bit)
- m_aw_data_i  in  N_MASTERS*AW_W  per-master AW FIFO head, master k at [k*AW_W +: AW_W]
- m_w_valid_i  in  N_MASTERS  per-master W FIFO non-empty
- m_w_data_i  in  N_MASTERS*W_W  per-master W FIFO head
- s_awready_i  in  1  slave accepts AW
- s_wready_i  in  1  slave accepts W beat
- aw_grant_o  out  N_MASTERS  one-hot AW pop pulse to the granted master's AW FIFO
- w_grant_o  out  N_MASTERS  one-hot W pop to the owner's W FIFO
- s_awvalid_o  out  1  slave AW valid
- s_aw_data_o  out  AW_W  registered AW payload
- s_wvalid_o  out  1  slave W valid
- s_w_data_o  out  W_W  W payload from owner
- len_err_o  out  1  one-cycle pulse on WLAST/beat-count mismatch
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, AXI_RST_i=1): state=IDLE, rr pointer=0, owner=0, beat count=0, s_aw_data_o=0. All outputs 0.
- States: IDLE, AW_SEND, W_BURST.
- IDLE, when |m_aw_valid_i:
  - Pick the first requester at or after the pointer, wrapping modulo N_MASTERS.
  - Same cycle: aw_grant_o[k]=1 for exactly one cycle, latch m_aw_data_i[k] into s_aw_data_o, owner<=k, beats_left<=len+1, pointer<=(k+1) mod N_MASTERS.
  - Next state is AW_SEND.
  - With no requester, stay in IDLE and keep outputs at 0.
- AW_SEND:
  - s_awvalid_o=1 and s_aw_data_o held stable until s_awready_i=1.
  - On the handshake cycle, next state is W_BURST; s_awvalid_o is 0 the following cycle.
  - Minimum AW latency: request cycle -> s_awvalid_o high the next cycle.
- W_BURST:
  - s_wvalid_o = m_w_valid_i[owner] and s_w_data_o = m_w_data_i[owner] (combinational).
  - w_grant_o[owner] = s_wvalid_o & s_wready_i; all other bits 0.
  - Each handshake decrements beats_left.
  - When beats_left==1 at a handshake, next state is IDLE.
  - If last=1 while beats_left!=1, or last=0 while beats_left==1: len_err_o pulses that cycle. Termination always follows the beat count, never last.
- The W channel of a non-owner is never granted; w_grant_o=0 outside W_BURST.
- No new AW is granted while busy. Requests arriving during a burst wait.
- The pointer advances only on a grant. A lone requester is re-granted back-to-back, with one IDLE cycle between bursts.
- len=15 gives 16 beats; the 5-bit beats_left never wraps.
- m_aw_valid_i dropping in AW_SEND or W_BURST has no effect, because the payload is already latched.
- Reset asserted mid-burst: immediate return to IDLE. The partial burst is abandoned and upstream FIFOs are not popped further.

Decomposition:
- Package axi_xbar_pkg:
  - AW_W and W_W widths.
  - Field offsets: AW_LEN_LSB=5, AW_ADDR_LSB=9, AW_ID_LSB=41, W_LAST_BIT=0.
  - State enum {IDLE, AW_SEND, W_BURST}.
- Sub-module rr_arbiter (param N):
  - Inputs req, advance. Outputs one-hot gnt and the pointer register.
  - Reused by the read-side arbiter.

Test Plan:
- Single write: master 1 AW len=0 addr 0x0001_0000, s_awready_i=1 -> aw_grant_o=3'b010 for 1 cycle; s_awvalid_o high the next cycle; one W beat popped via w_grant_o=3'b010; back to IDLE, len_err_o=0.
- Contention: masters 0, 1, 2 all request len=0 continuously -> grant order 0, 1, 2, 0, each separated by completed bursts.
- AW backpressure: s_awready_i low 3 cycles -> s_awvalid_o stays high with s_aw_data_o unchanged for 4 cycles; no W grant before the handshake.
- Burst len=3 with s_wready_i toggling 1,0,1,0... -> exactly 4 w_grant_o pulses to the owner; other masters' W FIFOs untouched; IDLE after the 4th beat.
- Early WLAST on beat 2 of len=3 -> len_err_o pulses on beat 2; the burst still completes after 4 beats.
- Reset asserted in W_BURST after 2 of 4 beats -> outputs 0 immediately; after release a new request from master 2 is granted (pointer reset to 0, first requester at or after 0).
